// File: rtl/packmem_rd_arbiter_pkg.sv
// Shared definitions for the packet-memory read arbiter: BPF load sizes,
// the CPU response payload and the size-to-byte-count helper.
package packmem_rd_arbiter_pkg;

  localparam logic [1:0] BPF_W = 2'b00;
  localparam logic [1:0] BPF_H = 2'b01;
  localparam logic [1:0] BPF_B = 2'b10;

  typedef struct packed {
    logic [31:0] data;
    logic        oob;
  } cpu_rsp_t;

  // Bytes touched by a load of the given size; the unused code 11 acts as a byte load.
  function automatic logic [2:0] bpf_nbytes(input logic [1:0] sz);
    case (sz)
      BPF_W:   bpf_nbytes = 3'd4;
      BPF_H:   bpf_nbytes = 3'd2;
      BPF_B:   bpf_nbytes = 3'd1;
      default: bpf_nbytes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/packmem_rd_arbiter_if.sv
// CPU, forwarder and packet-memory read buses of the arbiter.
// slave = the arbiter, master = whoever drives requests and models the memory.
interface packmem_rd_arbiter_if #(
  parameter int unsigned PACKET_BYTE_ADDR_WIDTH = 12,
  parameter int unsigned SNOOP_FWD_ADDR_WIDTH   = 9
);
  localparam int unsigned N  = PACKET_BYTE_ADDR_WIDTH - SNOOP_FWD_ADDR_WIDTH;
  localparam int unsigned BW = 2 * (1 << (N + 2));

  logic                              cpu_rd_en;
  logic [PACKET_BYTE_ADDR_WIDTH-1:0] cpu_byte_addr;
  logic [1:0]                        cpu_transfer_sz;
  logic                              cpu_rd_ready;
  logic                              cpu_rd_valid;
  logic [31:0]                       cpu_rd_data;
  logic                              cpu_rd_oob;
  logic [PACKET_BYTE_ADDR_WIDTH:0]   pkt_len;
  logic                              fwd_rd_en;
  logic [SNOOP_FWD_ADDR_WIDTH:0]     fwd_word_addr;
  logic                              fwd_rd_ready;
  logic                              fwd_rd_valid;
  logic [BW-1:0]                     fwd_rd_data;
  logic                              mem_rd_en;
  logic [SNOOP_FWD_ADDR_WIDTH:0]     mem_word_addr;
  logic [BW-1:0]                     mem_bigword;

  modport slave (
    input  cpu_rd_en, cpu_byte_addr, cpu_transfer_sz, pkt_len,
    input  fwd_rd_en, fwd_word_addr, mem_bigword,
    output cpu_rd_ready, cpu_rd_valid, cpu_rd_data, cpu_rd_oob,
    output fwd_rd_ready, fwd_rd_valid, fwd_rd_data,
    output mem_rd_en, mem_word_addr
  );

  modport master (
    output cpu_rd_en, cpu_byte_addr, cpu_transfer_sz, pkt_len,
    output fwd_rd_en, fwd_word_addr, mem_bigword,
    input  cpu_rd_ready, cpu_rd_valid, cpu_rd_data, cpu_rd_oob,
    input  fwd_rd_ready, fwd_rd_valid, fwd_rd_data,
    input  mem_rd_en, mem_word_addr
  );

endinterface

// File: rtl/packmem_rd_arbiter_read_size_adapter.sv
// Turns a sized, possibly unaligned CPU load into a bigword read: issues the
// word address now and extracts the big-endian bytes from the bigword next cycle.
module packmem_rd_arbiter_read_size_adapter #(
  parameter int unsigned PACKET_BYTE_ADDR_WIDTH = 12,
  parameter int unsigned SNOOP_FWD_ADDR_WIDTH   = 9
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [PACKET_BYTE_ADDR_WIDTH-1:0] i_byte_addr,
  input  logic [1:0]                        i_transfer_sz,
  input  logic [2*(1<<(PACKET_BYTE_ADDR_WIDTH-SNOOP_FWD_ADDR_WIDTH+2))-1:0] i_bigword,
  output logic [SNOOP_FWD_ADDR_WIDTH:0]     o_word_addr_c,
  output logic [31:0]                       o_data_c
);
  import packmem_rd_arbiter_pkg::*;

  localparam int unsigned N  = PACKET_BYTE_ADDR_WIDTH - SNOOP_FWD_ADDR_WIDTH;
  localparam int unsigned BW = 2 * (1 << (N + 2));

  logic [N-2:0] r_offset;
  logic [1:0]   r_sz;
  logic [31:0]  w_top;

  assign o_word_addr_c = i_byte_addr[PACKET_BYTE_ADDR_WIDTH-1:N-1];

  // Offset and size follow the address by one cycle, matching memory latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_offset <= '0;
      r_sz     <= BPF_W;
    end else begin
      r_offset <= i_byte_addr[N-2:0];
      r_sz     <= i_transfer_sz;
    end
  end

  // Byte at the offset becomes the MSB of the 32-bit window.
  assign w_top = 32'((i_bigword << {r_offset, 3'b000}) >> (BW - 32));

  always_comb begin
    o_data_c = {24'h0, w_top[31:24]};
    case (r_sz)
      BPF_W:   o_data_c = w_top;
      BPF_H:   o_data_c = {16'h0, w_top[31:16]};
      default: o_data_c = {24'h0, w_top[31:24]};
    endcase
  end

endmodule

// File: rtl/packmem_rd_arbiter.sv
// Shares the packet-memory read port between CPU loads (priority) and forwarder
// bigword reads, with a streak cap so the forwarder is never starved.
module packmem_rd_arbiter #(
  parameter int unsigned PACKET_BYTE_ADDR_WIDTH = 12,
  parameter int unsigned SNOOP_FWD_ADDR_WIDTH   = 9,
  parameter int unsigned STARVE_LIMIT           = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  packmem_rd_arbiter_if.slave  bus
);
  import packmem_rd_arbiter_pkg::*;

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned OW = PACKET_BYTE_ADDR_WIDTH + 2;

  logic [SW-1:0]                 r_streak;
  logic [SW-1:0]                 w_streak_nxt;
  logic                          r_armed;
  logic                          r_cpu_valid;
  logic                          r_fwd_valid;
  logic                          r_oob;
  logic                          w_cpu_grant;
  logic                          w_fwd_grant;
  logic                          w_oob;
  logic [SNOOP_FWD_ADDR_WIDTH:0] w_adp_addr;
  logic [31:0]                   w_adp_data;

  // r_armed holds off grants until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak    <= '0;
      r_armed     <= 1'b0;
      r_cpu_valid <= 1'b0;
      r_fwd_valid <= 1'b0;
      r_oob       <= 1'b0;
    end else begin
      r_streak    <= w_streak_nxt;
      r_armed     <= 1'b1;
      r_cpu_valid <= w_cpu_grant;
      r_fwd_valid <= w_fwd_grant;
      if (w_cpu_grant) r_oob <= w_oob;
    end
  end

  always_comb begin
    w_fwd_grant  = 1'b0;
    w_cpu_grant  = 1'b0;
    w_streak_nxt = r_streak;
    if (rst_n && r_armed) begin
      w_fwd_grant = bus.fwd_rd_en &&
                    (!bus.cpu_rd_en || (r_streak == SW'(STARVE_LIMIT)));
      w_cpu_grant = bus.cpu_rd_en && !w_fwd_grant;
    end
    if (w_fwd_grant || !bus.fwd_rd_en) w_streak_nxt = '0;
    else if (w_cpu_grant)              w_streak_nxt = r_streak + SW'(1);
  end

  // Widened so a load ending past the top of memory still reads as out of bounds.
  assign w_oob = (OW'(bus.cpu_byte_addr) + OW'(bpf_nbytes(bus.cpu_transfer_sz)))
                 > OW'(bus.pkt_len);

  packmem_rd_arbiter_read_size_adapter #(
    .PACKET_BYTE_ADDR_WIDTH(PACKET_BYTE_ADDR_WIDTH),
    .SNOOP_FWD_ADDR_WIDTH  (SNOOP_FWD_ADDR_WIDTH)
  ) u_adapter (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_byte_addr  (bus.cpu_byte_addr),
    .i_transfer_sz(bus.cpu_transfer_sz),
    .i_bigword    (bus.mem_bigword),
    .o_word_addr_c(w_adp_addr),
    .o_data_c     (w_adp_data)
  );

  assign bus.cpu_rd_ready  = w_cpu_grant;
  assign bus.fwd_rd_ready  = w_fwd_grant;
  assign bus.mem_rd_en     = w_cpu_grant || w_fwd_grant;
  assign bus.mem_word_addr = w_fwd_grant ? bus.fwd_word_addr : w_adp_addr;
  assign bus.cpu_rd_valid  = r_cpu_valid;
  assign bus.cpu_rd_oob    = r_oob;
  assign bus.cpu_rd_data   = w_adp_data;
  assign bus.fwd_rd_valid  = r_fwd_valid;
  assign bus.fwd_rd_data   = bus.mem_bigword;

endmodule

// File: tb/tb_packmem_rd_arbiter.sv
// Directed scoreboard bench for packmem_rd_arbiter: stimulus pushes expected
// responses, a negedge monitor pops and compares them when valids appear.
module tb_packmem_rd_arbiter;
  import packmem_rd_arbiter_pkg::*;

  localparam logic [63:0] BASE = 64'h0011223344556677;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  packmem_rd_arbiter_if #(.PACKET_BYTE_ADDR_WIDTH(12), .SNOOP_FWD_ADDR_WIDTH(9)) bus ();

  packmem_rd_arbiter #(
    .PACKET_BYTE_ADDR_WIDTH(12),
    .SNOOP_FWD_ADDR_WIDTH  (9),
    .STARVE_LIMIT          (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  cpu_rsp_t    cpu_q[$];
  logic [63:0] fwd_q[$];
  cpu_rsp_t    m_cpu_e;
  logic [63:0] m_fwd_e;

  // Memory contents: a fixed pattern with the word address folded into the low bits.
  function automatic logic [63:0] mem_fn(input logic [9:0] a);
    return BASE ^ 64'(a);
  endfunction

  always @(posedge clk) if (bus.mem_rd_en) bus.mem_bigword <= mem_fn(bus.mem_word_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (rst_n && bus.cpu_rd_valid) begin
      if (cpu_q.size() == 0) check("cpu_unexpected_valid", 64'(bus.cpu_rd_valid), 64'(0));
      else begin
        m_cpu_e = cpu_q.pop_front();
        check("cpu_rd_data", 64'(bus.cpu_rd_data), 64'(m_cpu_e.data));
        check("cpu_rd_oob",  64'(bus.cpu_rd_oob),  64'(m_cpu_e.oob));
      end
    end
    if (rst_n && bus.fwd_rd_valid) begin
      if (fwd_q.size() == 0) check("fwd_unexpected_valid", 64'(bus.fwd_rd_valid), 64'(0));
      else begin
        m_fwd_e = fwd_q.pop_front();
        check("fwd_rd_data", bus.fwd_rd_data, m_fwd_e);
      end
    end
  end

  task automatic cpu_read(input logic [11:0] addr, input logic [1:0] sz, input logic [12:0] plen,
                          input logic [31:0] exp_data, input logic exp_oob);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    bus.cpu_rd_en = 1'b1; bus.cpu_byte_addr = addr; bus.cpu_transfer_sz = sz; bus.pkt_len = plen;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus.cpu_rd_ready) begin
        got = 1'b1;
        check("cpu_mem_word_addr", 64'(bus.mem_word_addr), 64'(addr[11:2]));
        cpu_q.push_back('{data: exp_data, oob: exp_oob});
      end
    end
    check("cpu_rd_ready_seen", 64'(got), 64'(1));
    @(posedge clk); #1;
    bus.cpu_rd_en = 1'b0;
    bus.pkt_len = 13'h0;
  endtask

  // Both ports request; pat lists the expected winner per cycle (C or F).
  task automatic contend(input string pat, input int drop_at, input logic [11:0] caddr,
                         input logic [9:0] faddr, input logic [31:0] cexp);
    bit want_f;
    @(posedge clk); #1;
    bus.cpu_rd_en = 1'b1; bus.cpu_byte_addr = caddr; bus.cpu_transfer_sz = BPF_W;
    bus.pkt_len = 13'h1000; bus.fwd_word_addr = faddr;
    for (int c = 0; c < pat.len(); c++) begin
      bus.fwd_rd_en = (c != drop_at);
      @(negedge clk);
      want_f = (pat.getc(c) == 8'h46);
      check("arb_cpu_ready", 64'(bus.cpu_rd_ready), 64'(!want_f));
      check("arb_fwd_ready", 64'(bus.fwd_rd_ready), 64'(want_f));
      if (bus.cpu_rd_ready) cpu_q.push_back('{data: cexp, oob: 1'b0});
      if (bus.fwd_rd_ready) begin
        check("fwd_mem_word_addr", 64'(bus.mem_word_addr), 64'(faddr));
        fwd_q.push_back(mem_fn(faddr));
      end
      @(posedge clk); #1;
    end
    bus.cpu_rd_en = 1'b0; bus.fwd_rd_en = 1'b0;
  endtask

  typedef struct {
    logic [11:0] addr;
    logic [1:0]  sz;
    logic [12:0] plen;
    logic [31:0] data;
    logic        oob;
  } vec_t;

  vec_t vecs[10] = '{
    '{12'h005, 2'b01, 13'h1000, 32'h00001122, 1'b0},
    '{12'h007, 2'b00, 13'h1000, 32'h33445566, 1'b0},
    '{12'h004, 2'b10, 13'h1000, 32'h00000000, 1'b0},
    '{12'h005, 2'b11, 13'h1000, 32'h00000011, 1'b0},
    '{12'h007, 2'b00, 13'd10,   32'h33445566, 1'b1},
    '{12'h008, 2'b01, 13'd10,   32'h00000011, 1'b0},
    '{12'h00A, 2'b10, 13'd10,   32'h00000022, 1'b1},
    '{12'h009, 2'b10, 13'd10,   32'h00000011, 1'b0},
    '{12'hFFE, 2'b00, 13'h1000, 32'h22334455, 1'b1},
    '{12'hFFC, 2'b00, 13'h1000, 32'h00112233, 1'b0}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.cpu_rd_en = 1'b1; bus.cpu_byte_addr = '0; bus.cpu_transfer_sz = BPF_W;
    bus.pkt_len = '0; bus.fwd_rd_en = 1'b1; bus.fwd_word_addr = '0; bus.mem_bigword = '0;
    repeat (3) @(negedge clk);
    check("rst_cpu_valid", 64'(bus.cpu_rd_valid), 64'(0));
    check("rst_fwd_valid", 64'(bus.fwd_rd_valid), 64'(0));
    check("rst_cpu_oob",   64'(bus.cpu_rd_oob),   64'(0));
    check("rst_cpu_ready", 64'(bus.cpu_rd_ready), 64'(0));
    check("rst_fwd_ready", 64'(bus.fwd_rd_ready), 64'(0));
    check("rst_streak",    64'(dut.r_streak),     64'(0));
    bus.cpu_rd_en = 1'b0; bus.fwd_rd_en = 1'b0;
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) cpu_read(vecs[i].addr, vecs[i].sz, vecs[i].plen, vecs[i].data, vecs[i].oob);

    contend("CCCCFCCCCF", -1, 12'h000, 10'd2, 32'h00112233);
    repeat (2) @(posedge clk);
    contend("CCCCCCCF", 2, 12'h000, 10'd3, 32'h00112233);
    repeat (2) @(posedge clk);

    // Forwarder alone, back-to-back.
    @(posedge clk); #1;
    bus.fwd_rd_en = 1'b1;
    for (int a = 0; a < 3; a++) begin
      bus.fwd_word_addr = 10'(a);
      @(negedge clk);
      check("fwd_alone_ready", 64'(bus.fwd_rd_ready), 64'(1));
      check("fwd_alone_addr", 64'(bus.mem_word_addr), 64'(a));
      if (bus.fwd_rd_ready) fwd_q.push_back(mem_fn(10'(a)));
      @(posedge clk); #1;
    end
    bus.fwd_rd_en = 1'b0;
    repeat (2) @(posedge clk);

    // Reset pulse while a CPU grant is in flight under contention.
    @(posedge clk); #1;
    bus.cpu_rd_en = 1'b1; bus.cpu_byte_addr = 12'h005; bus.cpu_transfer_sz = BPF_H;
    bus.pkt_len = 13'h1000; bus.fwd_rd_en = 1'b1; bus.fwd_word_addr = 10'd2;
    @(negedge clk);
    check("rstmid_pre_ready", 64'(bus.cpu_rd_ready), 64'(1));
    if (bus.cpu_rd_ready) cpu_q.push_back('{data: 32'h00001122, oob: 1'b0});
    @(posedge clk); #1;
    @(negedge clk);
    check("rstmid_c0_ready", 64'(bus.cpu_rd_ready), 64'(1));
    check("rstmid_c0_streak", 64'(dut.r_streak), 64'(1));
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_c1_cpu_valid", 64'(bus.cpu_rd_valid), 64'(0));
    check("rstmid_c1_fwd_valid", 64'(bus.fwd_rd_valid), 64'(0));
    check("rstmid_c1_streak",    64'(dut.r_streak),     64'(0));
    check("rstmid_c1_regrant",   64'(bus.cpu_rd_ready), 64'(1));
    if (bus.cpu_rd_ready) cpu_q.push_back('{data: 32'h00001122, oob: 1'b0});
    @(posedge clk); #1;
    bus.cpu_rd_en = 1'b0; bus.fwd_rd_en = 1'b0;
    repeat (3) @(posedge clk);

    cpu_read(12'h006, BPF_H, 13'd8, 32'h00002233, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("cpu_q_drained", 64'(cpu_q.size()), 64'(0));
    check("fwd_q_drained", 64'(fwd_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
